free_list: RTL and testbench

//  Physical-register free list for the R10K rename path. It sits between retire and dispatch.

---
 rtl/free_list.sv | 88 ++++++++
 tb/tb_free_list.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module   : free_list
// Purpose  : Physical-register free list (availability bitmap) for R10K rename;
//            up to N tags handed out per cycle, retire frees and mispredict restore.
// Revision : 1.0 - initial release
// ============================================================================
module free_list #(
   parameter int  N         = 3,
   parameter int  PHYS_REGS = 64,
   parameter int  ARCH_REGS = 32,
   localparam int PRW       = $clog2(PHYS_REGS),
   localparam int CW        = $clog2(PHYS_REGS + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N-1:0]         alloc_en,
   output logic [N-1:0]         alloc_valid,
   output logic [N*PRW-1:0]     alloc_tag,
   output logic [CW-1:0]        free_count,
   input  logic [PHYS_REGS-1:0] free_mask,
   input  logic                 mispredict,
   input  logic [PHYS_REGS-1:0] restore_mask
);

   localparam logic [PHYS_REGS-1:0] c_init =
      {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
   localparam logic [PHYS_REGS-1:0] c_tag0 = PHYS_REGS'(1);

   logic [PHYS_REGS-1:0] r_avail;
   logic [PHYS_REGS-1:0] w_taken;
   logic [N-1:0]         w_valid;
   logic [N*PRW-1:0]     w_tag;
   logic [CW-1:0]        w_count;

   // Lane i takes the lowest bit left after lanes 0..i-1 removed theirs.
   always_comb begin
      logic [PHYS_REGS-1:0] w_rem;
      logic [PRW-1:0]       w_pick;
      logic                 w_found;
      w_rem   = r_avail;
      w_taken = '0;
      w_valid = '0;
      w_tag   = '0;
      for (int i = 0; i < N; i++) begin
         w_pick  = '0;
         w_found = 1'b0;
         for (int j = PHYS_REGS - 1; j >= 0; j--) begin
            if (w_rem[j]) begin
               w_pick  = PRW'(j);
               w_found = 1'b1;
            end
         end
         if (w_found && !reset) begin
            w_valid[i]             = 1'b1;
            w_tag[i*PRW +: PRW]    = w_pick;
            w_rem[w_pick]          = 1'b0;
            if (alloc_en[i]) begin
               w_taken[w_pick] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_count = '0;
      for (int j = 0; j < PHYS_REGS; j++) begin
         w_count = w_count + CW'(r_avail[j]);
      end
   end

   assign alloc_valid = w_valid;
   assign alloc_tag   = w_tag;
   assign free_count  = reset ? '0 : w_count;

   // Free wins over take on the (illegal) overlap; tag 0 is never made free.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_avail <= c_init & ~c_tag0;
      end else if (mispredict) begin
         r_avail <= restore_mask & ~c_tag0;
      end else begin
         r_avail <= ((r_avail & ~w_taken) | free_mask) & ~c_tag0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_free_list
// Purpose  : Directed bench for free_list (N=3, 64 phys, 32 arch) plus a model-checked run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_free_list;

   localparam int N   = 3;
   localparam int PR  = 64;
   localparam int AR  = 32;
   localparam int PRW = 6;
   localparam int CW  = 7;

   logic           clock = 1'b0;
   logic           reset;
   logic [N-1:0]   alloc_en;
   logic [N-1:0]   alloc_valid;
   logic [N*PRW-1:0] alloc_tag;
   logic [CW-1:0]  free_count;
   logic [PR-1:0]  free_mask;
   logic           mispredict;
   logic [PR-1:0]  restore_mask;

   int n_assert = 0;
   int n_fail   = 0;

   free_list #(.N(N), .PHYS_REGS(PR), .ARCH_REGS(AR)) dut (
      .clock        (clock),
      .reset        (reset),
      .alloc_en     (alloc_en),
      .alloc_valid  (alloc_valid),
      .alloc_tag    (alloc_tag),
      .free_count   (free_count),
      .free_mask    (free_mask),
      .mispredict   (mispredict),
      .restore_mask (restore_mask)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [N*PRW-1:0] tv(input int t0, input int t1, input int t2);
      return {PRW'(t2), PRW'(t1), PRW'(t0)};
   endfunction

   initial begin
      logic [PR-1:0]  m_avail, taken, fm, rm;
      logic [N-1:0]   ev, en;
      logic           mp;
      int             et[N];
      int             n;

      reset = 1'b1; alloc_en = '0; free_mask = '0; mispredict = 1'b0; restore_mask = '0;
      tick();
      tick();
      check("reset_valid", 64'(alloc_valid), 64'b000);
      check("reset_tag",   64'(alloc_tag), 64'd0);
      check("reset_count", 64'(free_count), 64'd0);

      reset = 1'b0;
      #1;
      check("post_reset_tags",  64'(alloc_tag), 64'(tv(32, 33, 34)));
      check("post_reset_valid", 64'(alloc_valid), 64'b111);
      check("post_reset_count", 64'(free_count), 64'd32);

      // Drain: ten full-width allocations, then only 62,63 remain.
      alloc_en = 3'b111;
      for (int k = 0; k < 10; k++) begin
         check("drain_tags",  64'(alloc_tag), 64'(tv(32 + 3*k, 33 + 3*k, 34 + 3*k)));
         check("drain_valid", 64'(alloc_valid), 64'b111);
         tick();
      end
      check("tail_tags",  64'(alloc_tag), 64'(tv(62, 63, 0)));
      check("tail_valid", 64'(alloc_valid), 64'b011);
      check("tail_count", 64'(free_count), 64'd2);
      tick();
      alloc_en = '0;
      check("empty_valid", 64'(alloc_valid), 64'b000);
      check("empty_tags",  64'(alloc_tag), 64'd0);
      check("empty_count", 64'(free_count), 64'd0);

      // Release of 40 is not visible until the next cycle.
      free_mask[40] = 1'b1;
      #1;
      check("free_no_bypass", 64'(alloc_valid), 64'b000);
      tick();
      free_mask = '0;
      check("free40_tag",   64'(alloc_tag), 64'(tv(40, 0, 0)));
      check("free40_valid", 64'(alloc_valid), 64'b001);
      check("free40_count", 64'(free_count), 64'd1);

      // Non-prefix allocation: lanes 0 and 2 only.
      free_mask[35] = 1'b1; free_mask[36] = 1'b1; free_mask[37] = 1'b1;
      tick();
      free_mask = '0;
      check("cand_tags",  64'(alloc_tag), 64'(tv(35, 36, 37)));
      check("cand_count", 64'(free_count), 64'd4);
      alloc_en = 3'b101;
      tick();
      alloc_en = '0;
      check("sparse_tags",  64'(alloc_tag), 64'(tv(36, 40, 0)));
      check("sparse_valid", 64'(alloc_valid), 64'b011);
      check("sparse_count", 64'(free_count), 64'd2);

      // Mispredict discards same-cycle alloc and free; bit 0 of restore is dropped.
      mispredict   = 1'b1;
      restore_mask = 64'hFFFF_0000_0000_000F;
      alloc_en     = 3'b111;
      free_mask    = '0;
      free_mask[50] = 1'b1; free_mask[20] = 1'b1;
      tick();
      mispredict = 1'b0; alloc_en = '0; free_mask = '0; restore_mask = '0;
      check("restore_tags",  64'(alloc_tag), 64'(tv(1, 2, 3)));
      check("restore_valid", 64'(alloc_valid), 64'b111);
      check("restore_count", 64'(free_count), 64'd19);

      // Full list: redundant frees and a free of tag 0 change nothing.
      free_mask = '1;
      tick();
      check("full_count", 64'(free_count), 64'd63);
      tick();
      free_mask = '0;
      check("full_again_count", 64'(free_count), 64'd63);
      check("full_tags", 64'(alloc_tag), 64'(tv(1, 2, 3)));

      // Reset mid-operation overrides alloc and free.
      alloc_en = 3'b111; free_mask = '1; reset = 1'b1;
      #1;
      check("midreset_valid", 64'(alloc_valid), 64'b000);
      check("midreset_count", 64'(free_count), 64'd0);
      tick();
      reset = 1'b0; alloc_en = '0; free_mask = '0;
      #1;
      check("midreset_tags",  64'(alloc_tag), 64'(tv(32, 33, 34)));
      check("midreset_after", 64'(free_count), 64'd32);

      // Random traffic checked against a bitmap model.
      m_avail = {{(PR-AR){1'b1}}, {AR{1'b0}}};
      for (int c = 0; c < 3000; c++) begin
         ev = '0; n = 0;
         for (int k = 0; k < N; k++) et[k] = 0;
         for (int j = 0; j < PR; j++) begin
            if (m_avail[j] && n < N) begin
               et[n] = j; ev[n] = 1'b1; n++;
            end
         end
         check("rnd_valid", 64'(alloc_valid), 64'(ev));
         check("rnd_tags",  64'(alloc_tag), 64'(tv(et[0], et[1], et[2])));
         check("rnd_count", 64'(free_count), 64'($countones(m_avail)));

         en = 3'($urandom_range(0, 7));
         taken = '0;
         for (int k = 0; k < N; k++) if (en[k] && ev[k]) taken[et[k]] = 1'b1;
         fm = '0;
         for (int j = 1; j < PR; j++)
            if (!m_avail[j] && $urandom_range(0, 11) == 0) fm[j] = 1'b1;
         mp = ($urandom_range(0, 39) == 0);
         rm = {$urandom, $urandom};
         check("rnd_no_take_free_overlap", taken & fm, 64'd0);

         alloc_en = en; free_mask = fm; mispredict = mp; restore_mask = rm;
         tick();
         m_avail = mp ? (rm & ~64'd1) : (((m_avail & ~taken) | fm) & ~64'd1);
      end
      alloc_en = '0; free_mask = '0; mispredict = 1'b0; restore_mask = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
